// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Holds the receiver FSM states, default widths and minimum bit period.
package uart_pkg;

  localparam int UART_DW       = 8;
  localparam int UART_CW       = 16;
  localparam int UART_COMP_MIN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-byte valid/ready handshake.
// master drives rx_data/rx_valid and samples rx_ready; slave is the consumer.
interface uart_rx_core_if
  import uart_pkg::*;
#(
  parameter int DW = UART_DW
);

  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep metastability chain, flops reset to 1 (idle line).
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver, 8-bit frames LSB-first, 1 stop, comp-cycle bits.
// Ports: clk, rst, en, comp, uart_rx, rx_bus (byte handshake), frame_err,
// overrun, err_clr, irq. Macro UART_RX_PARITY_EN adds par_en, par_odd,
// parity_err and the PARITY state.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DW          = UART_DW,
  parameter int CW          = UART_CW,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] comp,
  input  logic          uart_rx,
`ifdef UART_RX_PARITY_EN
  input  logic          par_en,
  input  logic          par_odd,
  output logic          parity_err,
`endif
  uart_rx_core_if.master rx_bus,
  output logic          frame_err,
  output logic          overrun,
  input  logic          err_clr,
  output logic          irq
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  logic rx_s;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          irq_q, irq_d;

  logic [CW-1:0] half_m1;
  logic [CW-1:0] full_m1;
  logic          at_half;
  logic          at_full;
  logic          last_bit;
  logic          par_go;
  logic          data_hit;
  logic          stop_hit;
  logic          deliver_ok;
  logic          err_src;

  assign half_m1  = (comp >> 1) - CW'(1);
  assign full_m1  = comp - CW'(1);
  assign at_half  = (cnt_q == half_m1);
  assign at_full  = (cnt_q == full_m1);
  assign last_bit = (bit_idx_q == BW'(DW-1));
  assign data_hit = en && (state_q == S_DATA) && at_full;
  assign stop_hit = en && (state_q == S_STOP) && at_full;

  // A full holding register only accepts a new byte if it drains this cycle.
  assign deliver_ok = stop_hit && (!rx_valid_q || rx_bus.rx_ready);

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic par_used_q, par_used_d;
  logic parity_err_q, parity_err_d;
  logic par_bad;

  assign par_go  = par_en;
  assign par_bad = par_used_q && (par_bit_q != ((^shift_q) ^ par_odd));
  assign err_src = frame_err_q | overrun_q | parity_err_q;

  always_comb begin
    par_bit_d    = par_bit_q;
    par_used_d   = par_used_q;
    parity_err_d = err_clr ? 1'b0 : parity_err_q;
    if (state_q == S_START) begin
      par_used_d = 1'b0;
    end
    if (en && (state_q == S_PARITY) && at_full) begin
      par_bit_d  = rx_s;
      par_used_d = 1'b1;
    end
    if (stop_hit && par_bad) begin
      parity_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit_q    <= 1'b0;
      par_used_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bit_q    <= par_bit_d;
      par_used_q   <= par_used_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign par_go  = 1'b0;
  assign err_src = frame_err_q | overrun_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (!rx_s) state_d = S_START;
        S_START:  if (at_half) state_d = rx_s ? S_IDLE : S_DATA;
        S_DATA:   if (at_full && last_bit) begin
                    state_d = par_go ? S_PARITY : S_STOP;
                  end
        S_PARITY: if (at_full) state_d = S_STOP;
        S_STOP:   if (at_full) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = err_clr ? 1'b0 : frame_err_q;
    overrun_d   = err_clr ? 1'b0 : overrun_q;
    irq_d       = rx_valid_q | err_src;

    if (state_d != state_q || state_q == S_IDLE || at_full) begin
      cnt_d = '0;
    end
    if (state_q == S_START) begin
      bit_idx_d = '0;
    end
    // Line order is LSB-first, so each bit enters at the MSB.
    if (data_hit) begin
      shift_d   = {rx_s, shift_q[DW-1:1]};
      bit_idx_d = bit_idx_q + BW'(1);
    end
    if (rx_valid_q && rx_bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (deliver_ok) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end
    if (stop_hit && !deliver_ok) begin
      overrun_d = 1'b1;
    end
    if (stop_hit && !rx_s) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      irq_q       <= irq_d;
    end
  end

  assign rx_bus.rx_data  = rx_data_q;
  assign rx_bus.rx_valid = rx_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against a sample-time model of the line.
// Model predicts outputs every cycle; literal checks pin key results.
`timescale 1ns/1ps
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int SS = 2;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          en      = 1'b0;
  logic          uart_rx = 1'b1;
  logic          err_clr = 1'b0;
  logic [CW-1:0] comp    = 16'd16;
  logic          frame_err;
  logic          overrun;
  logic          irq;
`ifdef UART_RX_PARITY_EN
  logic          par_en  = 1'b0;
  logic          par_odd = 1'b0;
  logic          parity_err;
`endif

  uart_rx_core_if #(.DW(DW)) bus ();

  always #5 clk = ~clk;

  uart_rx_core #(
    .DW          (DW),
    .CW          (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .comp       (comp),
    .uart_rx    (uart_rx),
`ifdef UART_RX_PARITY_EN
    .par_en     (par_en),
    .par_odd    (par_odd),
    .parity_err (parity_err),
`endif
    .rx_bus     (bus),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .irq        (irq)
  );

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;
  int vcnt   = 0;
  int icnt   = 0;
  logic [DW-1:0] last_data = '0;

  function automatic void check(string n, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endfunction

  // Model: time a frame from the start-detect cycle c. Start is sampled
  // at c+comp/2, line bit k (1-based after start) at c+comp/2+k*comp.
  logic [SS-1:0] m_pipe;
  bit            m_busy;
  int            m_t;
  logic [DW-1:0] m_bits;
  logic          m_pbit;
  logic          m_par_on;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ferr, m_ovr, m_perr, m_irq;

  always @(posedge clk) begin : model
    logic rxs;
    logic deliver;
    logic stopb;
    logic src;
    logic exp_par;
    int   h;
    int   k;
    if (rst) begin
      m_pipe   = '1;
      m_busy   = 1'b0;
      m_t      = 0;
      m_bits   = '0;
      m_pbit   = 1'b0;
      m_par_on = 1'b0;
      m_data   = '0;
      m_valid  = 1'b0;
      m_ferr   = 1'b0;
      m_ovr    = 1'b0;
      m_perr   = 1'b0;
      m_irq    = 1'b0;
    end else begin
      rxs     = m_pipe[SS-1];
      deliver = 1'b0;
      stopb   = 1'b1;
      src     = m_valid | m_ferr | m_ovr | m_perr;
      h       = int'(comp) / 2;
      if (!en) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (!rxs) begin
          m_busy   = 1'b1;
          m_t      = 0;
          m_par_on = 1'b0;
        end
      end else begin
        m_t++;
        if (m_t == h) begin
          if (rxs) m_busy = 1'b0;
        end else if (m_t > h && (m_t - h) % int'(comp) == 0) begin
          k = (m_t - h) / int'(comp);
          if (k <= DW) begin
            m_bits[k-1] = rxs;
`ifdef UART_RX_PARITY_EN
            if (k == DW) m_par_on = par_en;
`endif
          end else if (m_par_on && k == DW + 1) begin
            m_pbit = rxs;
          end else begin
            deliver = 1'b1;
            stopb   = rxs;
            m_busy  = 1'b0;
          end
        end
      end
      if (err_clr) begin
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
      end
      if (deliver) begin
        if (!m_valid || bus.rx_ready) begin
          m_data  = m_bits;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        if (!stopb) m_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
        exp_par = (^m_bits) ^ par_odd;
        if (m_par_on && m_pbit != exp_par) m_perr = 1'b1;
`endif
      end else if (m_valid && bus.rx_ready) begin
        m_valid = 1'b0;
      end
      m_irq  = src;
      m_pipe = {m_pipe[SS-2:0], uart_rx};
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("rx_valid", 32'(bus.rx_valid), 32'(m_valid));
      check("rx_data", 32'(bus.rx_data), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("irq", 32'(irq), 32'(m_irq));
`ifdef UART_RX_PARITY_EN
      check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
      if (bus.rx_valid === 1'b1) begin
        vcnt++;
        last_data = bus.rx_data;
      end
      if (irq === 1'b1) icnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    tick(int'(comp));
  endtask

  task automatic send(input logic [DW-1:0] d, input logic stopb,
                      input logic use_par, input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (use_par) send_bit(pbit);
    send_bit(stopb);
    uart_rx = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    bus.rx_ready = 1'b0;
    tick(3);
    armed = 1'b1;
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_data", 32'(bus.rx_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick(5);

    // 0xA5 8N1 with consumer ready: one-cycle valid and irq pulse.
    bus.rx_ready = 1'b1;
    vcnt = 0;
    icnt = 0;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    tick(20);
    check("a5_vcnt", 32'(vcnt), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_icnt", 32'(icnt), 32'd1);
    check("a5_ferr", 32'(frame_err), 32'd0);

    // 6-cycle glitch: start sample sees high, nothing reported.
    vcnt = 0;
    uart_rx = 1'b0;
    tick(6);
    uart_rx = 1'b1;
    tick(40);
    check("glitch_vcnt", 32'(vcnt), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);

    // 0x3C with low stop bit, held unread.
    bus.rx_ready = 1'b0;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(20);
    check("fe_data", 32'(bus.rx_data), 32'h3C);
    check("fe_valid", 32'(bus.rx_valid), 32'd1);
    check("fe_ferr", 32'(frame_err), 32'd1);
    pulse_clr();
    check("fe_clr", 32'(frame_err), 32'd0);
    bus.rx_ready = 1'b1;
    tick(2);
    check("fe_drain", 32'(bus.rx_valid), 32'd0);

    // Back-to-back 0x11, 0x22 with no reader: second byte overruns.
    bus.rx_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    tick(20);
    check("ovr_data", 32'(bus.rx_data), 32'h11);
    check("ovr_flag", 32'(overrun), 32'd1);
    bus.rx_ready = 1'b1;
    tick(1);
    check("ovr_drain", 32'(bus.rx_valid), 32'd0);
    pulse_clr();
    check("ovr_clr", 32'(overrun), 32'd0);

    // Reset during bit 4 of 0xFF, then 0x5A.
    uart_rx = 1'b0;
    tick(int'(comp));
    uart_rx = 1'b1;
    tick(4 * int'(comp) + int'(comp) / 2);
    rst = 1'b1;
    tick(2);
    check("mrst_valid", 32'(bus.rx_valid), 32'd0);
    check("mrst_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    tick(4 * int'(comp));
    vcnt = 0;
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    tick(20);
    check("mrst_vcnt", 32'(vcnt), 32'd1);
    check("mrst_5a", 32'(last_data), 32'h5A);
    check("mrst_ferr", 32'(frame_err), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);

    // en dropped mid-frame: frame dropped.
    vcnt = 0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    en = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b1);
    en = 1'b1;
    tick(40);
    check("en_vcnt", 32'(vcnt), 32'd0);

    // Minimum legal bit period.
    comp = 16'(UART_COMP_MIN);
    tick(4);
    vcnt = 0;
    send(8'h96, 1'b1, 1'b0, 1'b0);
    tick(20);
    check("c4_vcnt", 32'(vcnt), 32'd1);
    check("c4_data", 32'(last_data), 32'h96);
    comp = 16'd16;
    tick(4);

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07 expects bit 1.
    par_en  = 1'b1;
    par_odd = 1'b0;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    tick(20);
    check("par_bad", 32'(parity_err), 32'd1);
    check("par_data", 32'(last_data), 32'h07);
    pulse_clr();
    check("par_clr", 32'(parity_err), 32'd0);
    send(8'h07, 1'b1, 1'b1, 1'b1);
    tick(20);
    check("par_good", 32'(parity_err), 32'd0);
    par_odd = 1'b1;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    tick(20);
    check("par_odd", 32'(parity_err), 32'd0);
    par_en = 1'b0;
    tick(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Receive half of the UART peripheral. It recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) from the asynchronous uart_rx pin using the same clock-cycle bit-period divider as the transmit path. Received bytes go to the bus-side register block over a valid/ready handshake. Sticky error flags and an interrupt request go to irq_if.

Parameters:
DW, 8, data bits per frame
CW, 16, width of bit-period divider value
SYNC_STAGES, 2, flip-flops in uart_rx metastability synchronizer (min 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  receiver enable; low forces IDLE, in-flight frame dropped
comp  input  CW  bit period in clk cycles (legal >= 4)
uart_rx  input  1  serial line, idle high
rx_data  output  DW  received byte
rx_valid  output  1  rx_data holds an unread byte
rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: frame completed while rx_valid held
err_clr  input  1  clears frame_err, overrun (and parity_err)
irq  output  1  rx_valid | frame_err | overrun (| parity_err)

Behaviour:
- Interface fixed: one clock clk; reset rst synchronous, active-high.
- Reset: FSM=IDLE, counters 0, shift reg 0, rx_data=0, rx_valid=0, all flags 0, irq=0. Synchronizer flops reset to 1. Reset mid-frame abandons the frame, no flag set.
- rx_s = uart_rx after SYNC_STAGES flops. Pin-to-FSM latency = SYNC_STAGES cycles.
- Divider cnt counts 0..comp-1 and is cleared on every state change.
- IDLE: en && rx_s==0 -> START, cnt=0.
- START: at cnt==(comp>>1)-1, sample rx_s. If 0 -> DATA with cnt=0 and bit_idx=0. If 1 (glitch) -> IDLE, nothing reported.
- DATA: at cnt==comp-1, shift rx_s into the MSB of the shift reg (LSB-first line order). After bit_idx==DW-1 -> PARITY if enabled, else STOP.
- STOP: at cnt==comp-1 (mid stop bit), sample rx_s, go to IDLE, and deliver on the next edge:
  - rx_valid clear, or rx_ready high that cycle: rx_data<=shift reg, rx_valid<=1.
  - Otherwise: byte discarded, overrun<=1, old rx_data kept.
  - Stop sample 0: byte still delivered/discarded as above and frame_err<=1.
- Handshake: rx_valid clears on the clk after rx_valid&&rx_ready, except when a new delivery happens the same cycle (stays 1 with new data). rx_data is stable while rx_valid=1.
- Flags: err_clr and a new set in the same cycle -> set wins.
- en falling mid-frame: immediate IDLE, no delivery. Holding regs and flags kept.
- Returning to IDLE at mid stop bit allows back-to-back frames with no gap.
- irq is registered, 1 cycle after its sources.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: adds inputs par_en (1) and par_odd (1), output parity_err (sticky, cleared by err_clr, ORed into irq), and state PARITY. When par_en=1, PARITY samples at cnt==comp-1. A mismatch against XOR(data)^par_odd sets parity_err alongside delivery.
- Undefined: ports and state absent; DATA goes directly to STOP.

Decomposition:
- uart_pkg holds: the FSM state enum (IDLE, START, DATA, PARITY, STOP), the default widths DW/CW, and the minimum comp constant 4.
- Sub-module uart_rx_sync: SYNC_STAGES reset-to-1 synchronizer chain. Reused by future modem-control inputs.

Test Plan:
- comp=16, send 0xA5, 8N1, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5; flags 0; irq pulses.
- comp=16, low pulse of 6 cycles on idle line -> START aborts at sample cnt=7; rx_valid stays 0, no flags.
- comp=16, send 0x3C with stop bit 0 -> rx_data=0x3C, rx_valid=1, frame_err=1; err_clr -> frame_err=0 next cycle.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun=1; assert rx_ready -> rx_valid=0.
- Assert rst during bit 4 of 0xFF, release, send 0x5A -> only 0x5A delivered, no flags.
- UART_RX_PARITY_EN, par_en=1, par_odd=0, send 0x07 with parity bit 0 -> parity_err=1, rx_data=0x07; correct bit 1 -> parity_err stays 0.
